fpu_pipe_unit: RTL and testbench

//  Pipelined, parametrised IEEE-754-style floating-point unit: ADD, SUB and MUL on
//  (1+EXP_W+MAN_W)-bit operands, with valid/ready handshake and backpressure.

---
 rtl/fpu_pipe_unit.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_fpu_pipe_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_pipe_unit.sv
// fpu_pipe_unit: three-stage pipelined floating-point add/sub/mul
// with valid/ready backpressure and per-result/sticky exception flags.
module fpu_pipe_unit #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_y,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           out_flags,
    output logic [3:0]           sticky,
    input  logic                 sticky_clr
);

    localparam int FW  = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;
    localparam int PW  = 2 * MAN_W + 2;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(SW) + 1;

    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EMIN = EW'(1);

    localparam logic [FW-2:0] INF_M = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [FW-1:0] QNAN  = {FW{1'b1}};

    localparam logic [3:0] F_NV  = 4'b1000;
    localparam logic [3:0] F_OFX = 4'b0101;
    localparam logic [3:0] F_UFX = 4'b0011;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    // sig fields are {hidden, fraction, guard, round, sticky}
    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        logic             mul;
        logic             spec;
        logic [FW-1:0]    spec_y;
        logic [3:0]       spec_f;
        logic             sgn;
        logic [EW-1:0]    exp;
        logic             sub;
        logic [SW-1:0]    big;
        logic [SW-1:0]    sml;
        logic [PW-1:0]    prod;
    } s1_t;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        logic             spec;
        logic [FW-1:0]    spec_y;
        logic [3:0]       spec_f;
        logic             sgn;
        logic [EW-1:0]    exp;
        logic [SW-1:0]    nm;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic                 out_v_q;
    logic [FW-1:0]        y_q, y_d;
    logic [TAG_W-1:0]     tag_q;
    logic [3:0]           flg_q, flg_d;
    logic [3:0]           sticky_q;
    logic                 stall;

    assign stall     = out_v_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_v_q;
    assign out_y     = y_q;
    assign out_tag   = tag_q;
    assign out_flags = flg_q;
    assign sticky    = sticky_q;

    // ---------------- S1: unpack, classify, align or multiply
    logic             sa, sb, sbe;
    logic             is_mul, is_sub;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             za, zb, ia, ib, na, nb;
    logic             a_ge;
    logic [MAN_W:0]   siga, sigb;
    logic [EXP_W-1:0] e_big, e_sml, e_diff;
    logic [SW-1:0]    ext_big, ext_sml;
    logic [SW-1:0]    lost_mask, sml_al;
    logic             sml_lost;
    logic signed [EW-1:0] m_exp;

    assign is_mul = (in_op == OP_MUL);
    assign is_sub = (in_op == OP_SUB);

    assign sa = in_a[FW-1];
    assign sb = in_b[FW-1];
    assign ea = in_a[FW-2:MAN_W];
    assign eb = in_b[FW-2:MAN_W];
    assign ma = in_a[MAN_W-1:0];
    assign mb = in_b[MAN_W-1:0];

    assign sbe = sb ^ is_sub;

    // Subnormals have exp==0 and are flushed to signed zero
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (&ea) && (ma == '0);
    assign ib = (&eb) && (mb == '0);
    assign na = (&ea) && (ma != '0);
    assign nb = (&eb) && (mb != '0);

    assign siga = za ? '0 : {1'b1, ma};
    assign sigb = zb ? '0 : {1'b1, mb};

    assign a_ge  = (in_a[FW-2:0] >= in_b[FW-2:0]);
    assign e_big = a_ge ? ea : eb;
    assign e_sml = a_ge ? eb : ea;
    assign e_diff = e_big - e_sml;

    assign ext_big = {(a_ge ? siga : sigb), 3'b000};
    assign ext_sml = {(a_ge ? sigb : siga), 3'b000};

    assign lost_mask = ~({SW{1'b1}} << e_diff);
    assign sml_lost  = |(ext_sml & lost_mask);
    assign sml_al    = (ext_sml >> e_diff) | {{(SW-1){1'b0}}, sml_lost};

    assign m_exp = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    logic          sp_hit;
    logic [FW-1:0] sp_y;
    logic [3:0]    sp_f;

    always_comb begin
        sp_hit = 1'b0;
        sp_y   = '0;
        sp_f   = '0;
        if (na || nb) begin
            sp_hit = 1'b1;
            sp_y   = QNAN;
        end else if (is_mul) begin
            if ((ia && zb) || (za && ib)) begin
                sp_hit = 1'b1;
                sp_y   = QNAN;
                sp_f   = F_NV;
            end else if (ia || ib) begin
                sp_hit = 1'b1;
                sp_y   = {sa ^ sb, INF_M};
            end else if (za || zb) begin
                sp_hit = 1'b1;
                sp_y   = {sa ^ sb, {(FW-1){1'b0}}};
            end
        end else begin
            if (ia && ib && (sa != sbe)) begin
                sp_hit = 1'b1;
                sp_y   = QNAN;
                sp_f   = F_NV;
            end else if (ia) begin
                sp_hit = 1'b1;
                sp_y   = {sa, INF_M};
            end else if (ib) begin
                sp_hit = 1'b1;
                sp_y   = {sbe, INF_M};
            end
        end
    end

    always_comb begin
        s1_d        = '0;
        s1_d.v      = in_valid;
        s1_d.tag    = in_tag;
        s1_d.mul    = is_mul;
        s1_d.spec   = sp_hit;
        s1_d.spec_y = sp_y;
        s1_d.spec_f = sp_f;
        if (is_mul) begin
            s1_d.sgn  = sa ^ sb;
            s1_d.exp  = m_exp;
            s1_d.prod = PW'(siga) * PW'(sigb);
        end else begin
            s1_d.sgn = a_ge ? sa : sbe;
            s1_d.exp = {2'b00, e_big};
            s1_d.sub = sa ^ sbe;
            s1_d.big = ext_big;
            s1_d.sml = sml_al;
        end
    end

    // ---------------- S2: add/sub and normalise
    logic [SW:0]    sum;
    logic [LZW-1:0] lz;
    logic [PW-1:0]  pn;
    logic           top;
    logic [SW-1:0]  nm_mul;

    assign top    = s1_q.prod[PW-1];
    assign pn     = top ? s1_q.prod : (s1_q.prod << 1);
    assign nm_mul = {pn[PW-1 -: SW-1], |pn[PW-SW:0]};

    always_comb begin
        sum = s1_q.sub ? ({1'b0, s1_q.big} - {1'b0, s1_q.sml})
                       : ({1'b0, s1_q.big} + {1'b0, s1_q.sml});
        lz = '0;
        for (int i = 0; i < SW; i++) begin
            if (sum[i]) lz = LZW'(SW - 1 - i);
        end
    end

    always_comb begin
        s2_d        = '0;
        s2_d.v      = s1_q.v;
        s2_d.tag    = s1_q.tag;
        s2_d.spec   = s1_q.spec;
        s2_d.spec_y = s1_q.spec_y;
        s2_d.spec_f = s1_q.spec_f;
        s2_d.sgn    = s1_q.sgn;
        if (s1_q.mul) begin
            s2_d.exp = $signed(s1_q.exp)
                     + $signed({{(EW-1){1'b0}}, top});
            s2_d.nm  = nm_mul;
        end else if (sum[SW]) begin
            s2_d.exp = $signed(s1_q.exp) + EMIN;
            s2_d.nm  = {sum[SW:2], sum[1] | sum[0]};
        end else begin
            s2_d.exp = $signed(s1_q.exp) - $signed(EW'(lz));
            s2_d.nm  = sum[SW-1:0] << lz;
            if (sum == '0) s2_d.sgn = 1'b0;
        end
    end

    // ---------------- S3: round to nearest even, pack
    logic                 g_bit, rs_bit, up, inx;
    logic [MAN_W:0]       frc;
    logic signed [EW-1:0] e_r;

    assign g_bit  = s2_q.nm[2];
    assign rs_bit = s2_q.nm[1] | s2_q.nm[0];
    assign up     = g_bit && (rs_bit || s2_q.nm[3]);
    assign inx    = g_bit || rs_bit;
    assign frc    = {1'b0, s2_q.nm[SW-2:3]} + {{MAN_W{1'b0}}, up};
    assign e_r    = $signed(s2_q.exp)
                  + $signed({{(EW-1){1'b0}}, frc[MAN_W]});

    always_comb begin
        y_d   = '0;
        flg_d = '0;
        if (s2_q.spec) begin
            y_d   = s2_q.spec_y;
            flg_d = s2_q.spec_f;
        end else if (!s2_q.nm[SW-1]) begin
            y_d   = '0;
        end else if (e_r >= EMAX) begin
            y_d   = {s2_q.sgn, INF_M};
            flg_d = F_OFX;
        end else if (e_r < EMIN) begin
            y_d   = {s2_q.sgn, {(FW-1){1'b0}}};
            flg_d = F_UFX;
        end else begin
            y_d   = {s2_q.sgn, e_r[EXP_W-1:0], frc[MAN_W-1:0]};
            flg_d = {3'b000, inx};
        end
    end

    // ---------------- pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            out_v_q <= 1'b0;
            y_q     <= '0;
            tag_q   <= '0;
            flg_q   <= '0;
        end else if (!stall) begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            out_v_q <= s2_q.v;
            if (s2_q.v) begin
                y_q   <= y_d;
                tag_q <= s2_q.tag;
                flg_q <= flg_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else if (sticky_clr) begin
            sticky_q <= '0;
        end else if (out_v_q && out_ready) begin
            sticky_q <= sticky_q | flg_q;
        end
    end

endmodule

// File: tb/tb_fpu_pipe_unit.sv
// tb_fpu_pipe_unit: directed checks of fpu_pipe_unit arithmetic,
// latency, backpressure, sticky flags and mid-flight reset.
module tb_fpu_pipe_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_tag;
    logic [3:0]  out_flags;
    logic [3:0]  sticky;
    logic        sticky_clr;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_pipe_unit #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .sticky     (sticky),
        .sticky_clr (sticky_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NV = 20;
    logic [1:0]  v_op [NV] = '{
        2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2,
        2'd0, 2'd2, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0};
    logic [31:0] v_a [NV] = '{
        32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h7F7FFFFF,
        32'h7F800000, 32'h00800000, 32'h3F800000, 32'h40000000,
        32'h3F800001, 32'h40000000, 32'h7F800000, 32'hFF800000,
        32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h80000000,
        32'h80000001, 32'h7F7FFFFF, 32'h7F800000, 32'h00000001};
    logic [31:0] v_b [NV] = '{
        32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000,
        32'hFF800000, 32'h3F000000, 32'h33800000, 32'h3F800000,
        32'h33800000, 32'hC0400000, 32'h3F800000, 32'h40000000,
        32'h3F800000, 32'h00000000, 32'h40000000, 32'h3F800000,
        32'h3F800000, 32'h73000000, 32'h7F800000, 32'h00000000};
    logic [31:0] v_y [NV] = '{
        32'h40400000, 32'h40400000, 32'h00000000, 32'h7F800000,
        32'hFFFFFFFF, 32'h00000000, 32'h3F800000, 32'h3F800000,
        32'h3F800002, 32'hC0C00000, 32'h7F800000, 32'hFF800000,
        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40400000, 32'h80000000,
        32'h80000000, 32'h7F800000, 32'hFFFFFFFF, 32'h00000000};
    logic [3:0]  v_f [NV] = '{
        4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b1000,
        4'b0011, 4'b0001, 4'b0000, 4'b0001, 4'b0000,
        4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000,
        4'b0000, 4'b0000, 4'b0101, 4'b1000, 4'b0000};

    int          tx, rx;
    logic        prev_stall;
    logic [31:0] h_y;
    logic [3:0]  h_tag, h_flags;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input int idx, input logic [3:0] tg,
                         input bit clr_at_xfer);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = v_op[idx];
        in_a      = v_a[idx];
        in_b      = v_b[idx];
        in_tag    = tg;
        out_ready = 1'b1;
        #1;
        chk($sformatf("in_ready[%0d]", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        chk($sformatf("valid[%0d]", idx), 32'(out_valid), 32'd1);
        chk($sformatf("latency[%0d]", idx), 32'(lat), 32'd3);
        chk($sformatf("y[%0d]", idx), out_y, v_y[idx]);
        chk($sformatf("tag[%0d]", idx), 32'(out_tag), 32'(tg));
        chk($sformatf("flags[%0d]", idx), 32'(out_flags), 32'(v_f[idx]));
        if (clr_at_xfer) sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = 2'd0;
        in_a       = '0;
        in_b       = '0;
        in_tag     = '0;
        out_ready  = 1'b1;
        sticky_clr = 1'b0;

        #12;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst sticky", 32'(sticky), 32'd0);
        chk("rst out_y", out_y, 32'd0);
        chk("rst out_flags", 32'(out_flags), 32'd0);
        chk("rst out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 4'd5, 1'b0);
        do_op(1, 4'd1, 1'b0);
        do_op(2, 4'd2, 1'b0);
        @(negedge clk);
        chk("sticky clean", 32'(sticky), 32'd0);

        do_op(3, 4'd3, 1'b0);
        do_op(4, 4'd4, 1'b0);
        @(negedge clk);
        chk("sticky 1101", 32'(sticky), 32'b1101);

        sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky cleared", 32'(sticky), 32'd0);

        do_op(5, 4'd6, 1'b0);
        do_op(6, 4'd7, 1'b0);
        @(negedge clk);
        chk("sticky 0011", 32'(sticky), 32'b0011);

        for (int k = 7; k < NV; k++) do_op(k, 4'(k), 1'b0);
        @(negedge clk);
        chk("sticky 1111", 32'(sticky), 32'b1111);

        do_op(3, 4'd9, 1'b1);
        @(negedge clk);
        chk("sticky clr wins", 32'(sticky), 32'd0);
        do_op(4, 4'd10, 1'b0);
        @(negedge clk);
        chk("sticky 1000", 32'(sticky), 32'b1000);

        tx = 0;
        rx = 0;
        prev_stall = 1'b0;
        for (int cyc = 0; cyc < 300 && rx < 8; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("hold valid", 32'(out_valid), 32'd1);
                chk("hold y", out_y, h_y);
                chk("hold tag", 32'(out_tag), 32'(h_tag));
                chk("hold flags", 32'(out_flags), 32'(h_flags));
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (tx < 8);
            if (tx < 8) begin
                in_op  = v_op[tx];
                in_a   = v_a[tx];
                in_b   = v_b[tx];
                in_tag = 4'(tx);
            end
            #1;
            chk("in_ready rule", 32'(in_ready),
                32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                chk($sformatf("stream y[%0d]", rx), out_y, v_y[rx]);
                chk($sformatf("stream tag[%0d]", rx), 32'(out_tag), 32'(rx));
                chk($sformatf("stream flags[%0d]", rx),
                    32'(out_flags), 32'(v_f[rx]));
                rx++;
            end
            prev_stall = out_valid && !out_ready;
            h_y     = out_y;
            h_tag   = out_tag;
            h_flags = out_flags;
            if (in_valid && in_ready) tx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream count", 32'(rx), 32'd8);
        @(negedge clk);
        chk("stream drained", 32'(out_valid), 32'd0);
        chk("sticky stream", 32'(sticky), 32'b1111);

        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_op    = v_op[k];
            in_a     = v_a[k];
            in_b     = v_b[k];
            in_tag   = 4'(k + 12);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre-reset valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst sticky", 32'(sticky), 32'd0);
        chk("mid rst in_ready", 32'(in_ready), 32'd1);
        chk("mid rst out_y", out_y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("flushed %0d", k), 32'(out_valid), 32'd0);
        end
        do_op(9, 4'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
